// File: rtl/fp_sqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_sqrt_pkg
// Purpose  : Shared types and constants for the FP32 square-root dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package fp_sqrt_pkg;

    localparam int SIGN_W  = 1;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int FP_W    = SIGN_W + EXP_W + FRAC_W;
    localparam int FLAGS_W = 3;

    localparam logic [FP_W-1:0] QNAN_DEFAULT = 32'h7FC0_0000;

    // out_flags layout: {timeout, invalid, bypass}
    localparam int FLAG_TIMEOUT = 2;
    localparam int FLAG_INVALID = 1;
    localparam int FLAG_BYPASS  = 0;

    localparam logic [FLAGS_W-1:0] FLAGS_NONE    = 3'b000;
    localparam logic [FLAGS_W-1:0] FLAGS_TIMEOUT = FLAGS_W'(1 << FLAG_TIMEOUT);
    localparam logic [FLAGS_W-1:0] FLAGS_INVALID = FLAGS_W'(1 << FLAG_INVALID);
    localparam logic [FLAGS_W-1:0] FLAGS_BYPASS  = FLAGS_W'(1 << FLAG_BYPASS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLASS  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUT    = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/fp32_classify.sv
`default_nettype none
// ============================================================================
// Module   : fp32_classify
// Purpose  : Combinational FP32 operand classifier (zero/inf/NaN/sNaN/subnormal).
// Revision : 1.0 - initial release
// ============================================================================
module fp32_classify
    import fp_sqrt_pkg::*;
(
    input  logic [FP_W-1:0] data_i,
    output logic            is_zero,
    output logic            is_inf,
    output logic            is_nan,
    output logic            is_snan,
    output logic            is_sub,
    output logic            sign
);

    logic [EXP_W-1:0]  w_exp;
    logic [FRAC_W-1:0] w_frac;
    logic              w_exp_max;
    logic              w_exp_zero;
    logic              w_frac_zero;

    assign sign        = data_i[EXP_W+FRAC_W +: SIGN_W];
    assign w_exp       = data_i[FRAC_W +: EXP_W];
    assign w_frac      = data_i[FRAC_W-1:0];
    assign w_exp_max   = &w_exp;
    assign w_exp_zero  = ~|w_exp;
    assign w_frac_zero = ~|w_frac;

    assign is_zero = w_exp_zero & w_frac_zero;
    assign is_sub  = w_exp_zero & ~w_frac_zero;
    assign is_inf  = w_exp_max & w_frac_zero;
    assign is_nan  = w_exp_max & ~w_frac_zero;
    // The frac MSB is the quiet bit; a NaN with it clear is signalling.
    assign is_snan = is_nan & ~w_frac[FRAC_W-1];

endmodule
`default_nettype wire

// File: rtl/fp_sqrt_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : fp_sqrt_dispatch
// Purpose  : Front-end for an iterative FP32 sqrt core: special-operand bypass,
//            launch, timeout and result handshake. Build option:
//            SQRT_DENORM_FLUSH_EN flushes subnormal operands to signed zero.
// Revision : 1.0 - initial release
// ============================================================================
module fp_sqrt_dispatch
    import fp_sqrt_pkg::*;
#(
    parameter int unsigned     TIMEOUT_CYCLES = 255,
    parameter logic [FP_W-1:0] QNAN           = QNAN_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FP_W-1:0]    in_data,
    output logic               core_start,
    output logic [FP_W-1:0]    core_operand,
    input  logic               core_done,
    input  logic [FP_W-1:0]    core_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FP_W-1:0]    out_data,
    output logic [FLAGS_W-1:0] out_flags
);

`ifdef SQRT_DENORM_FLUSH_EN
    localparam bit FLUSH_DENORM = 1'b1;
`else
    localparam bit FLUSH_DENORM = 1'b0;
`endif
    localparam logic [7:0] TIMEOUT_C = TIMEOUT_CYCLES[7:0];

    state_e              state_q;
    logic                in_ready_q;
    logic [FP_W-1:0]     operand_q;
    logic                core_start_q;
    logic [7:0]          cnt_q;
    logic                out_valid_q;
    logic [FP_W-1:0]     out_data_q;
    logic [FLAGS_W-1:0]  out_flags_q;

    logic                w_is_zero, w_is_inf, w_is_nan, w_is_snan, w_is_sub, w_sign;
    logic                w_as_zero;
    logic                w_bypass;
    logic [FP_W-1:0]     w_byp_data;
    logic [FLAGS_W-1:0]  w_byp_flags;
    logic [7:0]          w_cnt_d;
    logic                w_timeout;

    fp32_classify u_classify (
        .data_i  (operand_q),
        .is_zero (w_is_zero),
        .is_inf  (w_is_inf),
        .is_nan  (w_is_nan),
        .is_snan (w_is_snan),
        .is_sub  (w_is_sub),
        .sign    (w_sign)
    );

    assign w_as_zero = w_is_zero | (FLUSH_DENORM & w_is_sub);

    // Priority: NaN, then (flushed) zero, then any negative, then +inf.
    always_comb begin
        w_bypass    = 1'b1;
        w_byp_data  = operand_q;
        w_byp_flags = FLAGS_BYPASS;
        if (w_is_nan) begin
            w_byp_data  = operand_q | 32'h0040_0000;
            w_byp_flags = w_is_snan ? FLAGS_INVALID : FLAGS_BYPASS;
        end else if (w_as_zero) begin
            w_byp_data  = {w_sign, {(FP_W-1){1'b0}}};
        end else if (w_sign) begin
            w_byp_data  = QNAN;
            w_byp_flags = FLAGS_INVALID;
        end else if (!w_is_inf) begin
            w_bypass    = 1'b0;
        end
    end

    // Saturating wait counter: the value it will hold after this WAIT cycle.
    assign w_cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign w_timeout = (w_cnt_d >= TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b0;
            operand_q    <= '0;
            core_start_q <= 1'b0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_flags_q  <= '0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        operand_q  <= in_data;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_CLASS;
                    end
                end
                ST_CLASS: begin
                    if (w_bypass) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= w_byp_data;
                        out_flags_q <= w_byp_flags;
                        state_q     <= ST_OUT;
                    end else begin
                        core_start_q <= 1'b1;
                        state_q      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= w_cnt_d;
                    // cnt_q == 0 marks the first WAIT cycle, where done may be stale.
                    if (core_done && (cnt_q != 8'd0)) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= core_result;
                        out_flags_q <= FLAGS_NONE;
                        state_q     <= ST_OUT;
                    end else if (w_timeout) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= QNAN;
                        out_flags_q <= FLAGS_TIMEOUT;
                        state_q     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign core_start   = core_start_q;
    assign core_operand = operand_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_flags    = out_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_sqrt_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_sqrt_dispatch
// Purpose  : Scoreboard bench for fp_sqrt_dispatch (default and short-timeout
//            instances behind a select mux); honours SQRT_DENORM_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_sqrt_dispatch;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  flags;
    } exp_t;

    localparam int unsigned TO_SHORT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        core_done = 1'b0;
    logic [31:0] core_result = '0;
    logic        out_ready = 1'b1;

    logic        d0_in_ready, d0_core_start, d0_out_valid;
    logic [31:0] d0_core_operand, d0_out_data;
    logic [2:0]  d0_out_flags;
    logic        d1_in_ready, d1_core_start, d1_out_valid;
    logic [31:0] d1_core_operand, d1_out_data;
    logic [2:0]  d1_out_flags;

    logic        in_ready, core_start, out_valid;
    logic [31:0] core_operand, out_data;
    logic [2:0]  out_flags;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          core_lat = 0;
    logic [31:0] core_res = '0;

    always #5 clk = ~clk;

    fp_sqrt_dispatch u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(d0_in_ready), .in_data(in_data),
        .core_start(d0_core_start), .core_operand(d0_core_operand),
        .core_done(core_done), .core_result(core_result),
        .out_valid(d0_out_valid), .out_ready(out_ready),
        .out_data(d0_out_data), .out_flags(d0_out_flags)
    );

    fp_sqrt_dispatch #(.TIMEOUT_CYCLES(TO_SHORT)) u_dut_to (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(d1_in_ready), .in_data(in_data),
        .core_start(d1_core_start), .core_operand(d1_core_operand),
        .core_done(core_done), .core_result(core_result),
        .out_valid(d1_out_valid), .out_ready(out_ready),
        .out_data(d1_out_data), .out_flags(d1_out_flags)
    );

    assign in_ready     = sel ? d1_in_ready     : d0_in_ready;
    assign core_start   = sel ? d1_core_start   : d0_core_start;
    assign core_operand = sel ? d1_core_operand : d0_core_operand;
    assign out_valid    = sel ? d1_out_valid    : d0_out_valid;
    assign out_data     = sel ? d1_out_data     : d0_out_data;
    assign out_flags    = sel ? d1_out_flags    : d0_out_flags;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: done rises core_lat cycles after the start pulse (0 = never);
    // a previous done is left high through the first WAIT cycle.
    initial begin
        int st = 0;
        bit armed = 0;
        forever begin
            @(posedge clk); #1;
            if (core_start) begin st = cyc; armed = 1; end
            if (armed && core_lat != 0 && (cyc - st) >= core_lat) begin
                core_done   = 1'b1;
                core_result = core_res;
            end else if (armed && (cyc - st) >= 2) begin
                core_done   = 1'b0;
            end
        end
    end

    // Monitor: every accepted output is popped and compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #2;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_output: got %h/%b expected none", out_data, out_flags);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_flags", {29'd0, out_flags}, {29'd0, e.flags});
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, output int acc);
        int k = 0;
        while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        acc      = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // exp_delay: out_valid cycle relative to core_start (core path) or accept (bypass).
    task automatic run_op(input logic [31:0] d, input int lat, input logic [31:0] res,
                          input logic [31:0] exp_d, input logic [2:0] exp_f,
                          input bit use_core, input int exp_delay, input int stall);
        int acc, s, v, starts;
        exp_t e;
        e.data = exp_d; e.flags = exp_f;
        sb.push_back(e);
        core_lat = lat; core_res = res;
        out_ready = (stall == 0);
        send(d, acc);
        s = -1; v = -1; starts = 0;
        for (int k = 0; k < 400; k++) begin
            if (core_start) begin
                starts++;
                if (s < 0) begin s = cyc; chk("core_operand", core_operand, d); end
            end
            if (out_valid) begin v = cyc; break; end
            @(posedge clk); #1;
        end
        chk("out_valid_seen", {31'd0, v >= 0}, 32'd1);
        if (use_core) begin
            chk("start_latency", s - acc, 32'd2);
            chk("start_pulses", starts, 32'd1);
            chk("done_latency", v - s, exp_delay);
        end else begin
            chk("start_pulses", starts, 32'd0);
            chk("bypass_latency", v - acc, exp_delay);
        end
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", out_data, exp_d);
            chk("stall_flags", {29'd0, out_flags}, {29'd0, exp_f});
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        chk("in_ready_hs", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("valid_dropped", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, k;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_core_start", {31'd0, core_start}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_post_rst", {31'd0, in_ready}, 32'd1);

        // core path: sqrt(4.0), 40-cycle core
        run_op(32'h4080_0000, 40, 32'h4000_0000, 32'h4000_0000, 3'b000, 1, 41, 0);
        // stale done still high in the first WAIT cycle must be ignored
        run_op(32'h4110_0000, 5, 32'h4040_0000, 32'h4040_0000, 3'b000, 1, 6, 0);
        // bypass specials
        run_op(32'hC000_0000, 0, 0, 32'h7FC0_0000, 3'b010, 0, 2, 0);
        run_op(32'h7F80_0001, 0, 0, 32'h7FC0_0001, 3'b010, 0, 2, 0);
        run_op(32'h8000_0000, 0, 0, 32'h8000_0000, 3'b001, 0, 2, 0);
        run_op(32'h0000_0000, 0, 0, 32'h0000_0000, 3'b001, 0, 2, 0);
        run_op(32'hFF80_0000, 0, 0, 32'h7FC0_0000, 3'b010, 0, 2, 0);
        run_op(32'hFFC0_1234, 0, 0, 32'hFFC0_1234, 3'b001, 0, 2, 0);
        // +inf with out_ready held low for 5 cycles
        run_op(32'h7F80_0000, 0, 0, 32'h7F80_0000, 3'b001, 0, 2, 5);
`ifdef SQRT_DENORM_FLUSH_EN
        run_op(32'h0000_0001, 0, 0, 32'h0000_0000, 3'b001, 0, 2, 0);
        run_op(32'h8000_0001, 0, 0, 32'h8000_0000, 3'b001, 0, 2, 0);
`else
        run_op(32'h0000_0001, 3, 32'h1A35_04F3, 32'h1A35_04F3, 3'b000, 1, 4, 0);
        run_op(32'h8000_0001, 0, 0, 32'h7FC0_0000, 3'b010, 0, 2, 0);
`endif

        // short-timeout instance: pure timeout, then done on the timeout cycle
        sel = 1'b1;
        @(posedge clk); #1;
        run_op(32'h4080_0000, 0, 0, 32'h7FC0_0000, 3'b100, 1, TO_SHORT + 1, 0);
        run_op(32'h4080_0000, TO_SHORT, 32'h3F80_0000, 32'h3F80_0000, 3'b000, 1, TO_SHORT + 1, 0);
        sel = 1'b0;
        @(posedge clk); #1;

        // reset while waiting on the core: the operand is dropped silently
        core_lat = 0;
        send(32'h4080_0000, acc);
        k = 0;
        while (!core_start && k < 20) begin @(posedge clk); #1; k++; end
        chk("mid_rst_start_seen", {31'd0, core_start}, 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_mid_rst", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen = 1;
            @(posedge clk); #1;
        end
        chk("no_out_after_rst", {31'd0, seen}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
